shift_logic_pipe: RTL and testbench

//  Parametrised, pipelined shift/logic execution unit for the processor ALU datapath.

---
 rtl/shift_logic_pipe.sv | 181 ++++++++++++++++++
 tb/tb_shift_logic_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_logic_pipe.sv
// Pipelined shift/logic unit: input capture register followed by one log2 shift stage per cycle.
// Define SHIFT_CARRY_EN to add the out_carry port and per-stage carry tracking.
module shift_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_CARRY_EN
  ,
  output logic             out_carry
`endif
);
  localparam int LOG2W = $clog2(WIDTH);
  localparam int LAST  = LOG2W - 1;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  function automatic logic [WIDTH-1:0] shift_step(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] v,
                                                  input int amt);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (op)
      OP_SLL:  shift_step = v << amt;
      OP_SRL:  shift_step = v >> amt;
      OP_SRA:  shift_step = sv >>> amt;
      OP_ROL:  shift_step = (v << amt) | (v >> (WIDTH - amt));
      OP_ROR:  shift_step = (v >> amt) | (v << (WIDTH - amt));
      default: shift_step = v;
    endcase
  endfunction

`ifdef SHIFT_CARRY_EN
  // Last bit leaving this step; the final carry is that of the last step that actually shifted.
  function automatic logic carry_step(input logic [2:0] op,
                                      input logic [WIDTH-1:0] v,
                                      input logic [WIDTH-1:0] nv,
                                      input int amt,
                                      input logic c);
    logic [LOG2W-1:0] hi;
    logic [LOG2W-1:0] lo;
    hi = LOG2W'(WIDTH - amt);
    lo = LOG2W'(amt - 1);
    case (op)
      OP_SLL:         carry_step = v[hi];
      OP_SRL, OP_SRA: carry_step = v[lo];
      OP_ROL:         carry_step = nv[0];
      OP_ROR:         carry_step = nv[WIDTH-1];
      default:        carry_step = c;
    endcase
  endfunction
`endif

  logic             advance;
  logic             vld_p0;
  logic [2:0]       op_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [TAG_W-1:0] tag_p0;

  logic             vld_ps [LOG2W];
  logic [2:0]       op_ps  [LOG2W];
  logic [WIDTH-1:0] res_ps [LOG2W];
  logic [LOG2W-1:0] amt_ps [LOG2W];
  logic [TAG_W-1:0] tag_ps [LOG2W];

  logic             src_vld [LOG2W];
  logic [2:0]       src_op  [LOG2W];
  logic [WIDTH-1:0] src_res [LOG2W];
  logic [LOG2W-1:0] src_amt [LOG2W];
  logic [TAG_W-1:0] src_tag [LOG2W];
  logic [WIDTH-1:0] nxt_res [LOG2W];
`ifdef SHIFT_CARRY_EN
  logic             cry_ps  [LOG2W];
  logic             src_cry [LOG2W];
  logic             nxt_cry [LOG2W];
`endif

  assign advance    = !vld_ps[LAST] || out_ready;
  assign in_ready   = advance;
  assign out_valid  = vld_ps[LAST];
  assign out_result = res_ps[LAST];
  assign out_tag    = tag_ps[LAST];
`ifdef SHIFT_CARRY_EN
  assign out_carry  = cry_ps[LAST];
`endif

  always_comb begin
    // stage 0 reads the capture register and resolves the logic ops
    src_vld[0] = vld_p0;
    src_op[0]  = op_p0;
    src_amt[0] = b_p0[LOG2W-1:0];
    src_tag[0] = tag_p0;
    case (op_p0)
      OP_AND:  src_res[0] = a_p0 & b_p0;
      OP_OR:   src_res[0] = a_p0 | b_p0;
      OP_PASS: src_res[0] = a_p0;
      default: src_res[0] = a_p0;
    endcase
`ifdef SHIFT_CARRY_EN
    src_cry[0] = 1'b0;
`endif
    for (int k = 1; k < LOG2W; k++) begin
      src_vld[k] = vld_ps[k-1];
      src_op[k]  = op_ps[k-1];
      src_amt[k] = amt_ps[k-1];
      src_tag[k] = tag_ps[k-1];
      src_res[k] = res_ps[k-1];
`ifdef SHIFT_CARRY_EN
      src_cry[k] = cry_ps[k-1];
`endif
    end
    for (int k = 0; k < LOG2W; k++) begin
      nxt_res[k] = src_res[k];
`ifdef SHIFT_CARRY_EN
      nxt_cry[k] = src_cry[k];
`endif
      if (src_op[k] <= OP_ROR && src_amt[k][LAST-k]) begin
        nxt_res[k] = shift_step(src_op[k], src_res[k], 1 << (LAST - k));
`ifdef SHIFT_CARRY_EN
        nxt_cry[k] = carry_step(src_op[k], src_res[k], nxt_res[k], 1 << (LAST - k), src_cry[k]);
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      op_p0  <= '0;
      a_p0   <= '0;
      b_p0   <= '0;
      tag_p0 <= '0;
      for (int k = 0; k < LOG2W; k++) begin
        vld_ps[k] <= 1'b0;
        op_ps[k]  <= '0;
        res_ps[k] <= '0;
        amt_ps[k] <= '0;
        tag_ps[k] <= '0;
`ifdef SHIFT_CARRY_EN
        cry_ps[k] <= 1'b0;
`endif
      end
    end else if (advance) begin
      vld_p0 <= in_valid;
      op_p0  <= in_op;
      a_p0   <= in_a;
      b_p0   <= in_b;
      tag_p0 <= in_tag;
      for (int k = 0; k < LOG2W; k++) begin
        vld_ps[k] <= src_vld[k];
        op_ps[k]  <= src_op[k];
        res_ps[k] <= nxt_res[k];
        amt_ps[k] <= src_amt[k];
        tag_ps[k] <= src_tag[k];
`ifdef SHIFT_CARRY_EN
        cry_ps[k] <= nxt_cry[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_shift_logic_pipe.sv
// Scoreboard bench for shift_logic_pipe at WIDTH=32: directed vectors, stall, and reset flush.
module tb_shift_logic_pipe;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
`ifdef SHIFT_CARRY_EN
  logic          out_carry;
`endif

  shift_logic_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
`ifdef SHIFT_CARRY_EN
    , .out_carry(out_carry)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    logic          c;
  } exp_t;

  exp_t          sbq[$];
  int            checks   = 0;
  int            failures = 0;
  logic          hold     = 1'b0;
  logic [W-1:0]  hres     = '0;
  logic [TW-1:0] htag     = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic mon_step();
    exp_t e;
    if (reset) begin
      hold = 1'b0;
      return;
    end
    if (hold) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_result", 64'(out_result), 64'(hres));
      chk("stall_tag", 64'(out_tag), 64'(htag));
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 64'(out_valid), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("result", 64'(out_result), 64'(e.res));
        chk("tag", 64'(out_tag), 64'(e.tag));
`ifdef SHIFT_CARRY_EN
        chk("carry", 64'(out_carry), 64'(e.c));
`endif
      end
    end
    hold = out_valid && !out_ready;
    hres = out_result;
    htag = out_tag;
  endtask

  always @(negedge clock) mon_step();

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag, input logic [W-1:0] er, input logic ec);
    bit acc;
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      n++;
    end
    if (acc) begin
      e.tag = tag;
      e.res = er;
      e.c   = ec;
      sbq.push_back(e);
    end else begin
      chk("send_timeout", 64'(acc), 64'(1));
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_empty", 64'(sbq.size()), 64'(0));
  endtask

  task automatic stall_proc();
    int n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("stall_setup", 64'(out_valid), 64'(1));
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_result", 64'(out_result), 64'(0));
    chk("reset_out_tag", 64'(out_tag), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));
    @(posedge clock);
    #1;

    // latency: output visible after the fifth edge following accept
    send(3'b000, 32'h0000_0001, 32'd31, 4'd1, 32'h8000_0000, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock);
      chk($sformatf("latency_%0d", i), 64'(out_valid), 64'(i == 6));
    end
    drain();

    // shifts, rotates, logic, zero shift, boundary amounts
    send(3'b010, 32'h8000_0000, 32'd4,        4'd2,  32'hF800_0000, 1'b0);
    send(3'b001, 32'h8000_0000, 32'd4,        4'd3,  32'h0800_0000, 1'b0);
    send(3'b001, 32'h0000_0018, 32'd4,        4'd4,  32'h0000_0001, 1'b1);
    send(3'b100, 32'h0000_0001, 32'd1,        4'd5,  32'h8000_0000, 1'b1);
    send(3'b011, 32'h8000_0001, 32'd4,        4'd6,  32'h0000_0018, 1'b0);
    send(3'b000, 32'h1234_ABCD, 32'd0,        4'd7,  32'h1234_ABCD, 1'b0);
    send(3'b101, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd8, 32'h0F00_0F00, 1'b0);
    send(3'b110, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd9, 32'hFFF0_FFF0, 1'b0);
    send(3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 4'd10, 32'hDEAD_BEEF, 1'b0);
    send(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'h0000_0001, 1'b0);
    send(3'b010, 32'h7000_0000, 32'd28,       4'd12, 32'h0000_0007, 1'b0);
    send(3'b011, 32'h0000_0003, 32'd31,       4'd13, 32'h8000_0001, 1'b1);
    drain();

    // back-to-back stream with a 4-cycle output stall
    fork
      begin
        for (int t = 0; t < 8; t++)
          send(3'b000, 32'h0000_0001, 32'hFFFF_FFE0 | 32'(t), 4'(t), 32'(1) << t, 1'b0);
      end
      stall_proc();
    join
    drain();

    // reset with ops in flight discards them
    send(3'b000, 32'h0000_0001, 32'd1, 4'd1, 32'h0000_0002, 1'b0);
    send(3'b000, 32'h0000_0001, 32'd2, 4'd2, 32'h0000_0004, 1'b0);
    send(3'b000, 32'h0000_0001, 32'd3, 4'd3, 32'h0000_0008, 1'b0);
    reset = 1'b1;
    sbq.delete();
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("flush_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("flush_quiet_%0d", i), 64'(out_valid), 64'(0));
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    send(3'b111, 32'hCAFE_F00D, 32'h0, 4'd15, 32'hCAFE_F00D, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
